// File: rtl/bpsm_sequencer_if.sv
// Bus Pirate sequencer bundle: command/result FIFOs, pin driver, SPI, ADC, LA and status.
interface bpsm_sequencer_if #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned BP_PINS    = 8
);
    // run/flush control from the register file
    logic                  run;
    logic                  flush;
    // command FIFO (first-word-fall-through)
    logic [FIFO_WIDTH-1:0] cmd_data;
    logic                  cmd_empty;
    logic                  cmd_pop;
    // result FIFO
    logic [FIFO_WIDTH-1:0] res_data;
    logic                  res_push;
    logic                  res_full;
    // IO pin driver
    logic                  io_wr;
    logic [BP_PINS-1:0]    io_value;
    // SPI shifter
    logic                  spi_req;
    logic [7:0]            spi_wdata;
    logic                  spi_done;
    logic [7:0]            spi_rdata;
    // ADC interface
    logic                  adc_req;
    logic [3:0]            adc_chan;
    logic                  adc_done;
    logic [11:0]           adc_result;
    // logic analyzer and status
    logic                  la_start;
    logic                  la_stop;
    logic                  active;
    logic                  halted;
    logic                  err_opcode;
    logic                  err_timeout;

    // Sequencer side
    modport master (
        input  run, flush, cmd_data, cmd_empty, res_full,
               spi_done, spi_rdata, adc_done, adc_result,
        output cmd_pop, res_data, res_push, io_wr, io_value,
               spi_req, spi_wdata, adc_req, adc_chan,
               la_start, la_stop, active, halted, err_opcode, err_timeout
    );

    // Environment side: FIFOs, engines, register file
    modport slave (
        output run, flush, cmd_data, cmd_empty, res_full,
               spi_done, spi_rdata, adc_done, adc_result,
        input  cmd_pop, res_data, res_push, io_wr, io_value,
               spi_req, spi_wdata, adc_req, adc_chan,
               la_start, la_stop, active, halted, err_opcode, err_timeout
    );
endinterface

// File: rtl/bpsm_sequencer.sv
// Bus Pirate command sequencer: fetches one command word at a time, dispatches it to
// the pin driver, SPI, ADC, LA control or a delay counter, and pushes engine results.
module bpsm_sequencer #(
    parameter int unsigned FIFO_WIDTH     = 16,
    parameter int unsigned BP_PINS        = 8,
    parameter int unsigned DELAY_PRESCALE = 4,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                clk,
    input  logic                rst,
    bpsm_sequencer_if.master    bus
);

    localparam int unsigned ARG_W = 8;
    localparam int unsigned DLY_W = $clog2(255 * DELAY_PRESCALE + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [7:0] OP_IO       = 8'h81;
    localparam logic [7:0] OP_DELAY    = 8'h84;
    localparam logic [7:0] OP_SPI      = 8'h08;
    localparam logic [7:0] OP_ADC      = 8'h85;
    localparam logic [7:0] OP_LA_START = 8'hFE;
    localparam logic [7:0] OP_LA_STOP  = 8'hFF;
    localparam logic [7:0] OP_HALT     = 8'hFD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_DELAY,
        S_SPI_WAIT,
        S_ADC_WAIT,
        S_PUSH,
        S_HALT
    } state_t;

    state_t                r_state;
    logic [7:0]            r_opcode;
    logic [ARG_W-1:0]      r_arg;
    logic [DLY_W-1:0]      r_dly_cnt;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic                  r_run_d;

    logic                  r_cmd_pop;
    logic [FIFO_WIDTH-1:0] r_res_data;
    logic                  r_res_push;
    logic                  r_io_wr;
    logic [BP_PINS-1:0]    r_io_value;
    logic                  r_spi_req;
    logic [7:0]            r_spi_wdata;
    logic                  r_adc_req;
    logic [3:0]            r_adc_chan;
    logic                  r_la_start;
    logic                  r_la_stop;
    logic                  r_active;
    logic                  r_halted;
    logic                  r_err_opcode;
    logic                  r_err_timeout;

    // Sequencer FSM; active/halted are updated alongside every state change so they
    // always match the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_opcode      <= '0;
            r_arg         <= '0;
            r_dly_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_run_d       <= 1'b0;
            r_cmd_pop     <= 1'b0;
            r_res_data    <= '0;
            r_res_push    <= 1'b0;
            r_io_wr       <= 1'b0;
            r_io_value    <= '0;
            r_spi_req     <= 1'b0;
            r_spi_wdata   <= '0;
            r_adc_req     <= 1'b0;
            r_adc_chan    <= '0;
            r_la_start    <= 1'b0;
            r_la_stop     <= 1'b0;
            r_active      <= 1'b0;
            r_halted      <= 1'b0;
            r_err_opcode  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_cmd_pop  <= 1'b0;
            r_res_push <= 1'b0;
            r_io_wr    <= 1'b0;
            r_la_start <= 1'b0;
            r_la_stop  <= 1'b0;
            r_run_d    <= bus.run;

            if (bus.flush) begin
                // Abort whatever is in flight; pin values stay where they are.
                r_state       <= S_IDLE;
                r_spi_req     <= 1'b0;
                r_adc_req     <= 1'b0;
                r_dly_cnt     <= '0;
                r_tmo_cnt     <= '0;
                r_err_opcode  <= 1'b0;
                r_err_timeout <= 1'b0;
                r_active      <= 1'b0;
                r_halted      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.run && !bus.cmd_empty) begin
                            r_cmd_pop <= 1'b1;
                            r_opcode  <= bus.cmd_data[15:8];
                            r_arg     <= bus.cmd_data[7:0];
                            r_active  <= 1'b1;
                            r_state   <= S_DECODE;
                        end
                    end

                    S_DECODE: begin
                        r_tmo_cnt <= '0;
                        case (r_opcode)
                            OP_IO: begin
                                r_io_value <= BP_PINS'(r_arg);
                                r_io_wr    <= 1'b1;
                                r_active   <= 1'b0;
                                r_state    <= S_IDLE;
                            end
                            OP_DELAY: begin
                                if (r_arg == '0) begin
                                    r_active <= 1'b0;
                                    r_state  <= S_IDLE;
                                end else begin
                                    r_dly_cnt <= DLY_W'(r_arg) * DLY_W'(DELAY_PRESCALE);
                                    r_state   <= S_DELAY;
                                end
                            end
                            OP_SPI: begin
                                r_spi_wdata <= r_arg;
                                r_spi_req   <= 1'b1;
                                r_state     <= S_SPI_WAIT;
                            end
                            OP_ADC: begin
                                r_adc_chan <= r_arg[3:0];
                                r_adc_req  <= 1'b1;
                                r_state    <= S_ADC_WAIT;
                            end
                            OP_LA_START: begin
                                r_la_start <= 1'b1;
                                r_active   <= 1'b0;
                                r_state    <= S_IDLE;
                            end
                            OP_LA_STOP: begin
                                r_la_stop <= 1'b1;
                                r_active  <= 1'b0;
                                r_state   <= S_IDLE;
                            end
                            OP_HALT: begin
                                r_active <= 1'b0;
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end
                            default: begin
                                r_err_opcode <= 1'b1;
                                r_active     <= 1'b0;
                                r_state      <= S_IDLE;
                            end
                        endcase
                    end

                    // Counter was loaded with the full occupancy, so leave on the last count.
                    S_DELAY: begin
                        if (r_dly_cnt <= DLY_W'(1)) begin
                            r_dly_cnt <= '0;
                            r_active  <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_dly_cnt <= r_dly_cnt - DLY_W'(1);
                        end
                    end

                    // Completion is checked before expiry so a late done still wins.
                    S_SPI_WAIT: begin
                        if (bus.spi_done) begin
                            r_spi_req  <= 1'b0;
                            r_res_data <= FIFO_WIDTH'({8'h08, bus.spi_rdata});
                            r_state    <= S_PUSH;
                        end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                            r_spi_req     <= 1'b0;
                            r_err_timeout <= 1'b1;
                            r_active      <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                        end
                    end

                    S_ADC_WAIT: begin
                        if (bus.adc_done) begin
                            r_adc_req  <= 1'b0;
                            r_res_data <= FIFO_WIDTH'({4'h0, bus.adc_result});
                            r_state    <= S_PUSH;
                        end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                            r_adc_req     <= 1'b0;
                            r_err_timeout <= 1'b1;
                            r_active      <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                        end
                    end

                    // Only this block pushes, so full cannot reassert before the strobe lands.
                    S_PUSH: begin
                        if (!bus.res_full) begin
                            r_res_push <= 1'b1;
                            r_active   <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end

                    S_HALT: begin
                        if (bus.run && !r_run_d) begin
                            r_halted <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end

                    default: begin
                        r_active <= 1'b0;
                        r_halted <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cmd_pop     = r_cmd_pop;
    assign bus.res_data    = r_res_data;
    assign bus.res_push    = r_res_push;
    assign bus.io_wr       = r_io_wr;
    assign bus.io_value    = r_io_value;
    assign bus.spi_req     = r_spi_req;
    assign bus.spi_wdata   = r_spi_wdata;
    assign bus.adc_req     = r_adc_req;
    assign bus.adc_chan    = r_adc_chan;
    assign bus.la_start    = r_la_start;
    assign bus.la_stop     = r_la_stop;
    assign bus.active      = r_active;
    assign bus.halted      = r_halted;
    assign bus.err_opcode  = r_err_opcode;
    assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_bpsm_sequencer.sv
// Self-checking bench for bpsm_sequencer: FIFO/engine responders, a command-level
// expectation model with a per-cycle compare process, and directed scenarios.
module tb_bpsm_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bpsm_sequencer_if #(.FIFO_WIDTH(16), .BP_PINS(8)) bus_if ();

    bpsm_sequencer #(
        .FIFO_WIDTH(16), .BP_PINS(8), .DELAY_PRESCALE(4), .TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Command FIFO contents and engine responder configuration
    logic [15:0] cmd_q[$];
    logic        spi_en = 1'b1;
    int          spi_lat = 20;
    logic [7:0]  spi_rsp = 8'h00;
    logic        adc_en = 1'b1;
    int          adc_lat = 5;
    logic [11:0] adc_rsp = 12'h000;

    // Expectation model: what each command must produce at the outputs
    logic [7:0]  exp_io_q[$];
    logic [7:0]  exp_spi_q[$];
    logic [3:0]  exp_adc_q[$];
    logic [15:0] exp_res_q[$];
    int          exp_la_start = 0;
    int          exp_la_stop = 0;
    logic        model_err_op = 1'b0;
    logic        model_err_tmo = 1'b0;

    task automatic expect_cmd(input logic [15:0] cmd, input logic respond, input logic [11:0] rsp);
        logic [7:0] op;
        logic [7:0] arg;
        op  = cmd[15:8];
        arg = cmd[7:0];
        case (op)
            8'h81: exp_io_q.push_back(arg);
            8'h84, 8'hFD: ;
            8'h08: begin
                exp_spi_q.push_back(arg);
                if (respond) exp_res_q.push_back({8'h08, rsp[7:0]});
                else model_err_tmo = 1'b1;
            end
            8'h85: begin
                exp_adc_q.push_back(arg[3:0]);
                if (respond) exp_res_q.push_back({4'h0, rsp});
                else model_err_tmo = 1'b1;
            end
            8'hFE: exp_la_start++;
            8'hFF: exp_la_stop++;
            default: model_err_op = 1'b1;
        endcase
    endtask

    task automatic issue(input logic [15:0] cmd, input logic respond, input logic [11:0] rsp);
        expect_cmd(cmd, respond, rsp);
        cmd_q.push_back(cmd);
    endtask

    // Command FIFO: sole driver of cmd_data/cmd_empty, pops on the sampled strobe
    initial begin
        logic pop;
        bus_if.cmd_data  = 16'h0000;
        bus_if.cmd_empty = 1'b1;
        forever begin
            @(negedge clk);
            pop = bus_if.cmd_pop;
            #1;
            if (pop && cmd_q.size() > 0) void'(cmd_q.pop_front());
            bus_if.cmd_empty = (cmd_q.size() == 0);
            bus_if.cmd_data  = (cmd_q.size() > 0) ? cmd_q[0] : 16'h0000;
        end
    end

    // SPI engine: done in the spi_lat-th cycle of a held request
    initial begin
        int cnt = 0;
        bus_if.spi_done  = 1'b0;
        bus_if.spi_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus_if.spi_done = 1'b0;
            if (bus_if.spi_req && spi_en && rst) begin
                cnt++;
                if (cnt == spi_lat) begin
                    bus_if.spi_done  = 1'b1;
                    bus_if.spi_rdata = spi_rsp;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    // ADC engine: done in the adc_lat-th cycle of a held request
    initial begin
        int cnt = 0;
        bus_if.adc_done   = 1'b0;
        bus_if.adc_result = 12'h000;
        forever begin
            @(negedge clk);
            bus_if.adc_done = 1'b0;
            if (bus_if.adc_req && adc_en && rst) begin
                cnt++;
                if (cnt == adc_lat) begin
                    bus_if.adc_done   = 1'b1;
                    bus_if.adc_result = adc_rsp;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    // Observed activity, owned by the compare process
    int unsigned cyc = 0;
    int unsigned pop_cyc[$];
    int          io_wr_cnt = 0;
    int          push_cnt = 0;
    logic [15:0] last_res = 16'h0000;
    int          la_start_cnt = 0;
    int          la_stop_cnt = 0;
    int          spi_len = 0;
    int          last_spi_len = 0;
    int          adc_len = 0;
    int          last_adc_len = 0;
    logic [7:0]  model_io = 8'h00;

    // Compare process: every cycle, DUT outputs against the expectation model
    initial begin
        logic prev_spi = 1'b0;
        logic prev_adc = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                model_io = 8'h00;
                prev_spi = 1'b0;
                prev_adc = 1'b0;
                spi_len  = 0;
                adc_len  = 0;
            end else begin
                if (bus_if.cmd_pop) pop_cyc.push_back(cyc);
                if (bus_if.io_wr) begin
                    check("io_wr_expected", 32'(exp_io_q.size() > 0), 32'h1);
                    if (exp_io_q.size() > 0) begin
                        model_io = exp_io_q.pop_front();
                        io_wr_cnt++;
                    end
                end
                check("io_value", 32'(bus_if.io_value), 32'(model_io));
                if (bus_if.res_push) begin
                    check("res_push_expected", 32'(exp_res_q.size() > 0), 32'h1);
                    if (exp_res_q.size() > 0)
                        check("res_data", 32'(bus_if.res_data), 32'(exp_res_q.pop_front()));
                    push_cnt++;
                    last_res = bus_if.res_data;
                end
                if (bus_if.spi_req && !prev_spi) begin
                    check("spi_req_expected", 32'(exp_spi_q.size() > 0), 32'h1);
                    if (exp_spi_q.size() > 0)
                        check("spi_wdata", 32'(bus_if.spi_wdata), 32'(exp_spi_q.pop_front()));
                end
                if (bus_if.adc_req && !prev_adc) begin
                    check("adc_req_expected", 32'(exp_adc_q.size() > 0), 32'h1);
                    if (exp_adc_q.size() > 0)
                        check("adc_chan", 32'(bus_if.adc_chan), 32'(exp_adc_q.pop_front()));
                end
                if (bus_if.spi_req) spi_len++;
                else if (prev_spi) begin last_spi_len = spi_len; spi_len = 0; end
                if (bus_if.adc_req) adc_len++;
                else if (prev_adc) begin last_adc_len = adc_len; adc_len = 0; end
                if (bus_if.la_start) la_start_cnt++;
                if (bus_if.la_stop)  la_stop_cnt++;
                check("active_halted_excl", 32'(bus_if.active & bus_if.halted), 32'h0);
                prev_spi = bus_if.spi_req;
                prev_adc = bus_if.adc_req;
            end
        end
    end

    // Wait until the FIFO is drained and the sequencer has been idle for 3 cycles
    task automatic wait_quiet(input int budget, input string name);
        int quiet = 0;
        for (int i = 0; i < budget && quiet < 3; i++) begin
            @(negedge clk);
            if (cmd_q.size() == 0 && !bus_if.active && !bus_if.cmd_pop) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check({name, "_quiet_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pop_gap(input int base, input string name, input int exp);
        if (pop_cyc.size() < base + 2) check({name, "_pops_seen"}, 32'(pop_cyc.size() - base), 32'h2);
        else check(name, pop_cyc[base+1] - pop_cyc[base], 32'(exp));
    endtask

    function automatic logic [63:0] all_outputs();
        return {bus_if.cmd_pop, bus_if.res_data, bus_if.res_push, bus_if.io_wr, bus_if.io_value,
                bus_if.spi_req, bus_if.spi_wdata, bus_if.adc_req, bus_if.adc_chan,
                bus_if.la_start, bus_if.la_stop, bus_if.active, bus_if.halted,
                bus_if.err_opcode, bus_if.err_timeout, 6'b0};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios
    initial begin
        int base;
        int p0;
        bus_if.run      = 1'b0;
        bus_if.flush    = 1'b0;
        bus_if.res_full = 1'b0;

        // Reset values
        wait_cycles(3);
        check("reset_outputs", 32'(all_outputs() != 64'h0), 32'h0);
        rst = 1'b1;
        wait_cycles(2);
        check("idle_after_reset_active", 32'(bus_if.active), 32'h0);

        // Pin writes, back-to-back fetch spacing
        bus_if.run = 1'b1;
        base = pop_cyc.size();
        issue(16'h81FF, 1'b1, 12'h0);
        issue(16'h8100, 1'b1, 12'h0);
        wait_quiet(200, "io");
        check("io_wr_count", 32'(io_wr_cnt), 32'h2);
        check("io_value_final", 32'(bus_if.io_value), 32'h00);
        check("io_active_end", 32'(bus_if.active), 32'h0);
        pop_gap(base, "io_pop_gap", 2);

        // 15-tick delay: 60 cycles in DELAY, next pop 62 cycles after the first
        base = pop_cyc.size();
        issue(16'h840F, 1'b1, 12'h0);
        issue(16'h8155, 1'b1, 12'h0);
        wait_quiet(400, "delay");
        pop_gap(base, "delay15_pop_gap", 62);
        check("delay_io_value", 32'(bus_if.io_value), 32'h55);

        // Zero delay returns at once
        base = pop_cyc.size();
        issue(16'h8400, 1'b1, 12'h0);
        issue(16'h81AA, 1'b1, 12'h0);
        wait_quiet(200, "delay0");
        pop_gap(base, "delay0_pop_gap", 2);
        check("delay0_io_value", 32'(bus_if.io_value), 32'hAA);

        // SPI transfer with 20-cycle engine latency
        spi_lat = 20; spi_rsp = 8'h55; spi_en = 1'b1;
        p0 = push_cnt;
        issue(16'h08AA, 1'b1, 12'h055);
        wait_quiet(200, "spi");
        check("spi_push_count", 32'(push_cnt - p0), 32'h1);
        check("spi_res_literal", 32'(last_res), 32'h0855);
        check("spi_req_len", 32'(last_spi_len), 32'd20);
        check("spi_req_end", 32'(bus_if.spi_req), 32'h0);

        // SPI result held back by a full result FIFO
        spi_rsp = 8'h3C;
        bus_if.res_full = 1'b1;
        p0 = push_cnt;
        issue(16'h08AA, 1'b1, 12'h03C);
        wait_cycles(40);
        check("full_no_push", 32'(push_cnt - p0), 32'h0);
        check("full_still_active", 32'(bus_if.active), 32'h1);
        bus_if.res_full = 1'b0;
        wait_quiet(50, "spi_full");
        check("full_push_count", 32'(push_cnt - p0), 32'h1);
        check("full_res_literal", 32'(last_res), 32'h083C);

        // ADC sample
        adc_lat = 5; adc_rsp = 12'hABC; adc_en = 1'b1;
        p0 = push_cnt;
        issue(16'h8503, 1'b1, 12'hABC);
        wait_quiet(100, "adc");
        check("adc_push_count", 32'(push_cnt - p0), 32'h1);
        check("adc_res_literal", 32'(last_res), 32'h0ABC);

        // Done in the very cycle the timeout would expire: result still taken
        adc_lat = 1024; adc_rsp = 12'h123;
        p0 = push_cnt;
        issue(16'h8507, 1'b1, 12'h123);
        wait_quiet(1200, "adc_edge");
        check("adc_edge_push", 32'(push_cnt - p0), 32'h1);
        check("adc_edge_res", 32'(last_res), 32'h0123);
        check("adc_edge_no_tmo", 32'(bus_if.err_timeout), 32'h0);

        // ADC never answers: request held exactly TIMEOUT cycles, then error, no push
        adc_en = 1'b0;
        p0 = push_cnt;
        issue(16'h8503, 1'b0, 12'h0);
        wait_quiet(1200, "adc_tmo");
        check("tmo_req_len", 32'(last_adc_len), 32'd1024);
        check("tmo_err", 32'(bus_if.err_timeout), 32'(model_err_tmo));
        check("tmo_err_literal", 32'(bus_if.err_timeout), 32'h1);
        check("tmo_no_push", 32'(push_cnt - p0), 32'h0);
        check("tmo_adc_req", 32'(bus_if.adc_req), 32'h0);
        adc_en = 1'b1;

        // LA start, halt, resume on run rising edge, LA stop
        issue(16'hFE00, 1'b1, 12'h0);
        issue(16'hFD00, 1'b1, 12'h0);
        issue(16'hFF00, 1'b1, 12'h0);
        wait_cycles(30);
        check("la_start_count", 32'(la_start_cnt), 32'(exp_la_start));
        check("la_start_literal", 32'(la_start_cnt), 32'h1);
        check("halted", 32'(bus_if.halted), 32'h1);
        check("halt_no_fetch", 32'(cmd_q.size()), 32'h1);
        bus_if.run = 1'b0;
        wait_cycles(3);
        check("halt_hold_run_low", 32'(bus_if.halted), 32'h1);
        bus_if.run = 1'b1;
        wait_quiet(50, "resume");
        check("la_stop_count", 32'(la_stop_cnt), 32'(exp_la_stop));
        check("la_stop_literal", 32'(la_stop_cnt), 32'h1);
        check("resumed", 32'(bus_if.halted), 32'h0);

        // Unknown opcode
        issue(16'h3300, 1'b1, 12'h0);
        wait_quiet(50, "badop");
        check("err_opcode", 32'(bus_if.err_opcode), 32'(model_err_op));
        check("err_opcode_literal", 32'(bus_if.err_opcode), 32'h1);

        // Flush mid SPI_WAIT clears request and errors
        spi_en = 1'b0;
        p0 = push_cnt;
        issue(16'h08AA, 1'b0, 12'h0);
        wait_cycles(10);
        check("pre_flush_spi_req", 32'(bus_if.spi_req), 32'h1);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        model_err_op = 1'b0; model_err_tmo = 1'b0;
        check("flush_spi_req", 32'(bus_if.spi_req), 32'h0);
        check("flush_active", 32'(bus_if.active), 32'h0);
        check("flush_err_opcode", 32'(bus_if.err_opcode), 32'(model_err_op));
        check("flush_err_timeout", 32'(bus_if.err_timeout), 32'h0);
        wait_cycles(20);
        check("flush_no_push", 32'(push_cnt - p0), 32'h0);
        check("flush_io_kept", 32'(bus_if.io_value), 32'hAA);
        spi_en = 1'b1;

        // Flush coinciding with a fetch suppresses the pop
        issue(16'h815A, 1'b1, 12'h0);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        check("flush_fetch_no_pop", 32'(bus_if.cmd_pop), 32'h0);
        check("flush_fetch_queued", 32'(cmd_q.size()), 32'h1);
        wait_quiet(50, "flush_fetch");
        check("flush_fetch_io", 32'(bus_if.io_value), 32'h5A);

        // Asynchronous reset mid DELAY, applied between clock edges
        issue(16'h84FF, 1'b1, 12'h0);
        wait_cycles(20);
        check("pre_reset_active", 32'(bus_if.active), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'(all_outputs() != 64'h0), 32'h0);
        check("async_reset_io", 32'(bus_if.io_value), 32'h00);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(5);
        check("post_reset_idle", 32'(bus_if.active), 32'h0);
        check("post_reset_queue", 32'(cmd_q.size()), 32'h0);

        // Every expected event was consumed
        check("exp_io_drained", 32'(exp_io_q.size()), 32'h0);
        check("exp_res_drained", 32'(exp_res_q.size()), 32'h0);
        check("exp_spi_drained", 32'(exp_spi_q.size()), 32'h0);
        check("exp_adc_drained", 32'(exp_adc_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
